// File: rtl/m_cp0_pkg.sv
// m_cp0_pkg: CP0 register numbers, exception codes and SR/Cause field positions
package m_cp0_pkg;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
    localparam int IM_LSB  = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_LSB = 2;
endpackage

// File: rtl/m_cp0_req.sv
// m_cp0_req: combinational interrupt/exception request and next ExcCode select
//   hwint, im     : interrupt pins and SR.IM mask
//   ie, exl       : SR.IE, SR.EXL
//   exc_code_in   : exception code of the M-stage instruction
//   req           : take interrupt/exception this cycle
//   exc_code_next : code latched into Cause (interrupt wins over exception)
module m_cp0_req
    import m_cp0_pkg::*;
#(
    parameter int HWINT_W = 6
) (
    input  logic [HWINT_W-1:0] hwint,
    input  logic [HWINT_W-1:0] im,
    input  logic               ie,
    input  logic               exl,
    input  logic [4:0]         exc_code_in,
    output logic               req,
    output logic [4:0]         exc_code_next
);
    logic int_req, exc_req;
    assign int_req       = |(hwint & im) & ie & ~exl;
    assign exc_req       = (exc_code_in != EXC_INT) & ~exl;
    assign req           = int_req | exc_req;
    assign exc_code_next = int_req ? EXC_INT : exc_code_in;
endmodule

// File: rtl/m_cp0.sv
// m_cp0: MIPS coprocessor 0 holding SR/Cause/EPC/PRId and raising the pipeline redirect request
//   clk, reset                    : clock, synchronous active-high reset
//   CP0_WE_en/addr/wdata          : mtc0 write port (suppressed when Req)
//   CP0_rdata                     : combinational mfc0 read of CP0_addr
//   VPC, BD_in, ExcCode_in        : M-stage PC, delay-slot flag, exception code
//   HWInt                         : level-sensitive interrupt pins
//   EXLclr                        : eret, clears SR.EXL (suppressed when Req)
//   Req, EPC_out                  : redirect request, current EPC
module m_cp0
    import m_cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2022_1120,
    parameter int          HWINT_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CP0_WE_en,
    input  logic [4:0]         CP0_addr,
    input  logic [31:0]        CP0_wdata,
    output logic [31:0]        CP0_rdata,
    input  logic [31:0]        VPC,
    input  logic               BD_in,
    input  logic [4:0]         ExcCode_in,
    input  logic [HWINT_W-1:0] HWInt,
    input  logic               EXLclr,
    output logic               Req,
    output logic [31:0]        EPC_out
);
    logic [HWINT_W-1:0] sr_im, cause_ip;
    logic               sr_exl, sr_ie, cause_bd;
    logic [4:0]         cause_exc, exc_code_next;
    logic [31:0]        epc, epc_next, sr_val, cause_val;

    m_cp0_req #(.HWINT_W(HWINT_W)) u_req (
        .hwint         (HWInt),
        .im            (sr_im),
        .ie            (sr_ie),
        .exl           (sr_exl),
        .exc_code_in   (ExcCode_in),
        .req           (Req),
        .exc_code_next (exc_code_next)
    );

    // a victim in a delay slot restarts at its branch
    assign epc_next = (VPC & ~32'd3) - (BD_in ? 32'd4 : 32'd0);
    assign EPC_out  = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_exc <= exc_code_next;
                cause_bd  <= BD_in;
                epc       <= epc_next;
            end else begin
                if (CP0_WE_en && CP0_addr == REG_SR) begin
                    sr_im  <= CP0_wdata[IM_LSB +: HWINT_W];
                    sr_exl <= CP0_wdata[EXL_BIT];
                    sr_ie  <= CP0_wdata[IE_BIT];
                end
                if (CP0_WE_en && CP0_addr == REG_EPC)
                    epc <= CP0_wdata;
                // later assignment lets eret override an mtc0 to SR.EXL
                if (EXLclr)
                    sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_val                       = '0;
        sr_val[IM_LSB +: HWINT_W]    = sr_im;
        sr_val[EXL_BIT]              = sr_exl;
        sr_val[IE_BIT]               = sr_ie;
        cause_val                    = '0;
        cause_val[BD_BIT]            = cause_bd;
        cause_val[IM_LSB +: HWINT_W] = cause_ip;
        cause_val[EXC_LSB +: 5]      = cause_exc;
        CP0_rdata = CP0_addr == REG_SR    ? sr_val    :
                    CP0_addr == REG_CAUSE ? cause_val :
                    CP0_addr == REG_EPC   ? epc       :
                    CP0_addr == REG_PRID  ? PRID_VALUE : '0;
    end
endmodule

// File: tb/tb_m_cp0.sv
// tb_m_cp0: scoreboard bench for m_cp0 with directed vectors
module tb_m_cp0;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CP0_WE_en = 1'b0;
    logic [4:0]  CP0_addr = '0;
    logic [31:0] CP0_wdata = '0;
    logic [31:0] CP0_rdata;
    logic [31:0] VPC = '0;
    logic        BD_in = 1'b0;
    logic [4:0]  ExcCode_in = '0;
    logic [5:0]  HWInt = '0;
    logic        EXLclr = 1'b0;
    logic        Req;
    logic [31:0] EPC_out;

    m_cp0 dut (
        .clk        (clk),
        .reset      (reset),
        .CP0_WE_en  (CP0_WE_en),
        .CP0_addr   (CP0_addr),
        .CP0_wdata  (CP0_wdata),
        .CP0_rdata  (CP0_rdata),
        .VPC        (VPC),
        .BD_in      (BD_in),
        .ExcCode_in (ExcCode_in),
        .HWInt      (HWInt),
        .EXLclr     (EXLclr),
        .Req        (Req),
        .EPC_out    (EPC_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_v(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.cyc  = cyc;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        CP0_addr = a;
        expect_v(0, exp, name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: DUT outputs are presented every cycle; compare on the falling edge
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                c = q.pop_front();
                tests++;
                act = c.kind == 0 ? CP0_rdata : c.kind == 1 ? {31'b0, Req} : EPC_out;
                if (c.cyc != cyc) begin
                    failed++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)", c.name, c.cyc, cyc);
                end else if (act !== c.exp) begin
                    failed++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin
        step();
        reset = 1'b0;
        rd(12, 32'h0, "reset_sr");
        expect_v(1, 32'd0, "reset_req");
        expect_v(2, 32'h0, "reset_epc_out");
        step();
        rd(13, 32'h0, "reset_cause");
        step();
        rd(14, 32'h0, "reset_epc");
        step();
        rd(15, 32'h2022_1120, "reset_prid");
        // enable all IM + IE with int line 2 high
        step();
        CP0_WE_en = 1'b1;
        CP0_addr  = 5'd12;
        CP0_wdata = 32'h0000_FC01;
        HWInt     = 6'b000100;
        VPC       = 32'h0000_1000;
        expect_v(1, 32'd0, "req_before_ie");
        step();
        CP0_WE_en = 1'b0;
        rd(12, 32'h0000_FC01, "sr_written");
        expect_v(1, 32'd1, "int_req");
        step();
        rd(13, 32'h0000_1000, "int_cause");
        expect_v(1, 32'd0, "req_masked_exl");
        expect_v(2, 32'h0000_1000, "int_epc");
        step();
        rd(12, 32'h0000_FC03, "sr_exl_set");
        // eret together with an mtc0 setting EXL: EXL must end up clear
        HWInt     = 6'b0;
        EXLclr    = 1'b1;
        CP0_WE_en = 1'b1;
        CP0_wdata = 32'h0000_FC03;
        expect_v(1, 32'd0, "req_during_eret");
        step();
        EXLclr    = 1'b0;
        CP0_WE_en = 1'b0;
        rd(12, 32'h0000_FC01, "eret_vs_mtc0");
        step();
        // plain EPC write, read-during-write returns the old value
        CP0_WE_en = 1'b1;
        CP0_wdata = 32'h0000_2000;
        rd(14, 32'h0000_1000, "epc_rdw_old");
        step();
        CP0_WE_en = 1'b0;
        rd(14, 32'h0000_2000, "epc_mtc0");
        step();
        // AdES in a delay slot
        ExcCode_in = 5'd5;
        BD_in      = 1'b1;
        VPC        = 32'h0000_3010;
        expect_v(1, 32'd1, "ades_req");
        step();
        ExcCode_in = 5'd0;
        BD_in      = 1'b0;
        rd(13, 32'h8000_0014, "ades_cause");
        expect_v(2, 32'h0000_300C, "ades_epc");
        expect_v(1, 32'd0, "ades_req_cleared");
        step();
        // EXL blocks both exception and interrupts
        ExcCode_in = 5'd4;
        HWInt      = 6'h3F;
        VPC        = 32'h0000_4000;
        expect_v(1, 32'd0, "exl_blocks_req");
        step();
        ExcCode_in = 5'd0;
        EXLclr     = 1'b1;
        expect_v(2, 32'h0000_300C, "exl_epc_kept");
        expect_v(1, 32'd0, "req_in_eret");
        step();
        EXLclr    = 1'b0;
        // pending interrupt retaken; concurrent mtc0 EPC must lose
        CP0_WE_en = 1'b1;
        CP0_addr  = 5'd14;
        CP0_wdata = 32'hDEAD_BEEC;
        VPC       = 32'h0000_5008;
        expect_v(1, 32'd1, "req_after_eret");
        step();
        CP0_WE_en = 1'b0;
        rd(13, 32'h0000_FC00, "int2_cause");
        expect_v(2, 32'h0000_5008, "epc_beats_mtc0");
        // reset one cycle after Req while EXL is set
        reset = 1'b1;
        step();
        reset = 1'b0;
        HWInt = 6'b0;
        rd(12, 32'h0, "rst2_sr");
        expect_v(1, 32'd0, "rst2_req");
        expect_v(2, 32'h0, "rst2_epc_out");
        step();
        rd(13, 32'h0, "rst2_cause");
        step();
        rd(14, 32'h0, "rst2_epc");
        step();
        step();
        while (q.size() > 0) begin
            chk_t c;
            c = q.pop_front();
            tests++;
            failed++;
            $display("FAIL %s: never checked (cycle %0d)", c.name, c.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
